palette_ram: RTL and testbench
==============================

Name: palette_ram

Overview:
- 16-entry x 8-bit palette register file between the video pipeline and the VGA/TV colour path.
- The video block drives the read address (palette index) and consumes the 8-bit BGR233 real colour combinationally.
- The CPU I/O side posts palette writes (index + colour). The block defers each write by a programmable number of 6 MHz pixel ticks, mimicking the original machine's delayed palette latch.
- It also keeps a pending-write status and a sticky overrun flag.

Parameters:
- WR_DELAY, 4: number of ce6 ticks between request acceptance and commit; legal range 1..15.
- RESET_PAL, 128'h0 (entry 0 in bits 7:0): reset contents of the 16 entries.

Ports:
- clk24 input 1: 24 MHz clock; all state on posedge.
- reset_n input 1: asynchronous, active-low reset.
- ce6 input 1: 6 MHz clock enable, one clk24 cycle wide.
- coloridx input 4: read address from the video block.
- realcolor output 8: palette[coloridx]; combinational, zero latency.
- wr_req input 1: single-cycle write strobe from the I/O decoder.
- wr_idx input 4: entry to write; sampled when wr_req=1.
- wr_data input 8: colour to write; sampled when wr_req=1.
- wr_pending output 1: 1 from acceptance until commit completes.
- wr_overrun output 1: sticky; set when wr_req arrives while a write is pending.
- ovr_clr input 1: clears wr_overrun.
- dbg_idx input 4: debug readback address.
- dbg_data output 8: palette[dbg_idx]; combinational.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - entries load RESET_PAL; FSM goes to IDLE; delay counter=0.
  - wr_pending=0, wr_overrun=0; latched idx/data=0.
  - realcolor and dbg_data reflect RESET_PAL immediately.
- Read paths: purely combinational from the register file.
  - A commit on cycle N is visible on realcolor from cycle N+1.
- FSM states: IDLE, WAIT, COMMIT.
- IDLE:
  - wr_req=1: latch wr_idx/wr_data, load counter=WR_DELAY, assert wr_pending, go to WAIT.
- WAIT:
  - On each ce6=1 cycle, decrement the counter.
  - When the counter reaches 0 by that decrement, go to COMMIT on the next clk24.
  - Non-ce6 cycles hold the counter.
- COMMIT (exactly one clk24 cycle):
  - write latched data to entry latched idx.
  - deassert wr_pending at the end of the cycle; return to IDLE.
- Total latency from wr_req to visibility: WR_DELAY ce6 ticks plus 2 clk24 cycles.
- wr_req while wr_pending=1 (WAIT or COMMIT):
  - Replace the latched idx/data (last writer wins) and set wr_overrun.
  - Restart the counter at WR_DELAY and stay in, or return to, WAIT.
  - If this happens in the COMMIT cycle, the old write still commits in that cycle and the new write is then pending.
- Same-cycle wr_req and ce6 in IDLE: the counter loads WR_DELAY; that ce6 does not count.
- ovr_clr and a new overrun in the same cycle: set wins.
- Reset mid-WAIT: the pending write is discarded and the entry keeps its reset value.
- Counter width is 4 bits with no wrap. WR_DELAY=0 is illegal; implementations clamp it to 1.
- Writing an index currently addressed by coloridx is not a hazard. realcolor changes on the cycle after COMMIT; no output glitch suppression is required.

Decomposition:
- Shared video package holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, COMMIT=2'd2);
  - the colour width constant (8);
  - the palette depth constant (16);
  - the default palette constant used for RESET_PAL.
- One natural sub-module: palette_wr_sched, containing the FSM, delay counter, latch and overrun logic. It emits a one-cycle commit strobe, index and data.
- The top level keeps the 16x8 register file and both read muxes.

Test Plan:
- Reset with RESET_PAL entry 5 = 8'hA5; coloridx=5 -> realcolor=8'hA5 and wr_pending=0 during and after reset.
- WR_DELAY=4, ce6 every 4th clk24; wr_req idx=3 data=8'h1C -> wr_pending high for 4 ce6 ticks +2 cycles; realcolor(idx3)=8'h1C exactly the cycle after COMMIT; never earlier.
- Back-to-back writes:
  - wr_req idx=2 data=8'h11, then after 2 ce6 ticks wr_req idx=2 data=8'h22.
  - Expect wr_overrun=1, entry 2 never takes 8'h11, and it takes 8'h22 WR_DELAY ticks after the second request.
  - Then ovr_clr clears the flag.
- wr_req on the COMMIT cycle (idx=7 then idx=8 data=8'hF0):
  - Entry 7 is written.
  - wr_pending stays 1.
  - Entry 8=8'hF0 after a further WR_DELAY ticks.
- Assert reset_n=0 mid-WAIT for write idx=9 data=8'h77 -> entry 9 stays at its RESET_PAL value, FSM is IDLE, wr_pending=0.
- Sweep coloridx 0..15 while dbg_idx sweeps in reverse, no writes -> both outputs match the expected register contents every cycle.

Source files
------------

// File: rtl/palette_ram_pkg.sv
// Shared video definitions for the palette register file.
//   - wr_state_e  : write-scheduler FSM encoding (IDLE / WAIT / COMMIT)
//   - COLOR_W     : BGR233 colour width
//   - PAL_DEPTH   : number of palette entries, IDX_W the matching index width
//   - CNT_W       : width of the deferred-write tick counter
//   - DEFAULT_PAL : default reset contents (entry 0 in bits 7:0)
//   - clamp_delay : maps a requested delay onto the legal 1..15 tick range
package palette_ram_pkg;

    localparam int COLOR_W   = 8;
    localparam int PAL_DEPTH = 16;
    localparam int IDX_W     = $clog2(PAL_DEPTH);
    localparam int CNT_W     = 4;

    localparam logic [PAL_DEPTH*COLOR_W-1:0] DEFAULT_PAL = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } wr_state_e;

    // A delay of zero would never leave WAIT, so it is treated as one tick;
    // anything wider than the counter saturates at its maximum.
    function automatic logic [CNT_W-1:0] clamp_delay(input int d);
        if (d < 1)
            return CNT_W'(1);
        if (d > (1 << CNT_W) - 1)
            return {CNT_W{1'b1}};
        return CNT_W'(d);
    endfunction

endpackage

// File: rtl/palette_ram_if.sv
// CPU-side palette write bus.
//   wr_req     : single-cycle write strobe from the I/O decoder
//   wr_idx     : palette entry to write (sampled with wr_req)
//   wr_data    : BGR233 colour to write (sampled with wr_req)
//   ovr_clr    : clears the sticky overrun flag
//   wr_pending : a write has been accepted and not yet committed
//   wr_overrun : sticky, a request arrived while a write was pending
// master = I/O decoder side, slave = palette block.
interface palette_ram_if;
    import palette_ram_pkg::*;

    logic               wr_req;
    logic [IDX_W-1:0]   wr_idx;
    logic [COLOR_W-1:0] wr_data;
    logic               ovr_clr;
    logic               wr_pending;
    logic               wr_overrun;

    modport master (
        output wr_req, wr_idx, wr_data, ovr_clr,
        input  wr_pending, wr_overrun
    );

    modport slave (
        input  wr_req, wr_idx, wr_data, ovr_clr,
        output wr_pending, wr_overrun
    );

endinterface

// File: rtl/palette_wr_sched.sv
// Deferred palette-write scheduler. Latches a CPU write, holds it for
// WR_DELAY 6 MHz ticks, then emits a one-cycle commit strobe with the
// latched index/data. A newer request always replaces the latched one.
//   clk24, reset_n           : 24 MHz clock, async active-low reset
//   ce6                      : 6 MHz tick enable
//   wr_req, wr_idx, wr_data  : write request
//   ovr_clr                  : clear sticky overrun
//   wr_pending, wr_overrun   : status
//   commit, commit_idx/data  : one-cycle register-file write port
module palette_wr_sched
    import palette_ram_pkg::*;
#(
    parameter int WR_DELAY = 4
) (
    input  logic               clk24,
    input  logic               reset_n,
    input  logic               ce6,
    input  logic               wr_req,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               ovr_clr,
    output logic               wr_pending,
    output logic               wr_overrun,
    output logic               commit,
    output logic [IDX_W-1:0]   commit_idx,
    output logic [COLOR_W-1:0] commit_data
);

    localparam logic [CNT_W-1:0] DELAY = clamp_delay(WR_DELAY);

    wr_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COLOR_W-1:0] data_q, data_d;
    logic               ovr_q, ovr_d;

    // NOTE: non-blocking assignments for every flop, so all state updates
    // on the same edge see each other's old values.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no
        // path through the case leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ovr_d   = ovr_q;

        if (ovr_clr)
            ovr_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A ce6 coinciding with the request is not counted.
                if (wr_req) begin
                    state_d = WAIT;
                    cnt_d   = DELAY;
                end
            end
            WAIT: begin
                if (wr_req) begin
                    cnt_d = DELAY;
                end else if (ce6) begin
                    // Counter never wraps; the tick reaching zero commits.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                // The old write commits this cycle from idx_q/data_q; a new
                // request simply becomes the next pending write.
                if (wr_req) begin
                    state_d = WAIT;
                    cnt_d   = DELAY;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_req) begin
            idx_d  = wr_idx;
            data_d = wr_data;
            // Placed after the clear so a simultaneous overrun wins.
            if (state_q != IDLE)
                ovr_d = 1'b1;
        end
    end

    assign wr_pending  = (state_q != IDLE);
    assign wr_overrun  = ovr_q;
    assign commit      = (state_q == COMMIT);
    assign commit_idx  = idx_q;
    assign commit_data = data_q;

endmodule

// File: rtl/palette_ram.sv
// 16 x 8 palette register file between the video pipeline and the colour
// output path, with CPU writes deferred by WR_DELAY 6 MHz ticks.
//   clk24, reset_n : 24 MHz clock, async active-low reset
//   ce6            : 6 MHz tick enable
//   coloridx       : palette index from the video block
//   realcolor      : BGR233 colour for coloridx (combinational)
//   dbg_idx        : debug readback index
//   dbg_data       : palette contents at dbg_idx (combinational)
//   wr_bus         : CPU write bus (slave side)
module palette_ram
    import palette_ram_pkg::*;
#(
    parameter int                             WR_DELAY  = 4,
    parameter logic [PAL_DEPTH*COLOR_W-1:0]   RESET_PAL = DEFAULT_PAL
) (
    input  logic               clk24,
    input  logic               reset_n,
    input  logic               ce6,
    input  logic [IDX_W-1:0]   coloridx,
    output logic [COLOR_W-1:0] realcolor,
    input  logic [IDX_W-1:0]   dbg_idx,
    output logic [COLOR_W-1:0] dbg_data,
    palette_ram_if.slave       wr_bus
);

    logic               commit;
    logic [IDX_W-1:0]   commit_idx;
    logic [COLOR_W-1:0] commit_data;

    logic [COLOR_W-1:0] pal_q [PAL_DEPTH];

    palette_wr_sched #(
        .WR_DELAY (WR_DELAY)
    ) u_sched (
        .clk24       (clk24),
        .reset_n     (reset_n),
        .ce6         (ce6),
        .wr_req      (wr_bus.wr_req),
        .wr_idx      (wr_bus.wr_idx),
        .wr_data     (wr_bus.wr_data),
        .ovr_clr     (wr_bus.ovr_clr),
        .wr_pending  (wr_bus.wr_pending),
        .wr_overrun  (wr_bus.wr_overrun),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data)
    );

    // NOTE: the palette must come out of reset with defined colours, so
    // these entries are reset flops rather than an inferred RAM.
    always_ff @(posedge clk24 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_DEPTH; i++)
                pal_q[i] <= RESET_PAL[i*COLOR_W +: COLOR_W];
        end else if (commit) begin
            pal_q[commit_idx] <= commit_data;
        end
    end

    // Both read ports are plain muxes; a commit shows up the next cycle.
    assign realcolor = pal_q[coloridx];
    assign dbg_data  = pal_q[dbg_idx];

endmodule

// File: tb/tb_palette_ram.sv
// Directed self-checking bench for palette_ram.
// Each step() lands on a clk24 negedge: outputs there reflect the previous
// posedge, and inputs driven there are sampled by the next posedge.
// ce6 is high on every 4th step.
module tb_palette_ram;

    localparam int WR_DELAY = 4;
    // Entry i holds i, except entry 5 = A5 and entry 9 = 99.
    localparam logic [127:0] RESET_PAL = 128'h0F0E0D0C0B0A9908_0706A50403020100;

    logic       clk24;
    logic       reset_n;
    logic       ce6;
    logic [3:0] coloridx;
    logic [7:0] realcolor;
    logic [3:0] dbg_idx;
    logic [7:0] dbg_data;

    palette_ram_if bus ();

    palette_ram #(
        .WR_DELAY  (WR_DELAY),
        .RESET_PAL (RESET_PAL)
    ) dut (
        .clk24     (clk24),
        .reset_n   (reset_n),
        .ce6       (ce6),
        .coloridx  (coloridx),
        .realcolor (realcolor),
        .dbg_idx   (dbg_idx),
        .dbg_data  (dbg_data),
        .wr_bus    (bus)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         ph     = 0;
    logic [7:0] exp_pal [16];

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {7'd0, obs}, {7'd0, exp});
    endtask

    task automatic step();
        @(negedge clk24);
        bus.wr_req  = 1'b0;
        bus.ovr_clr = 1'b0;
        ph++;
        ce6 = (ph % 4 == 0);
    endtask

    // Advance until the step that drives ce6 high; bounded by one ce6 period.
    task automatic align();
        int n = 0;
        do begin
            step();
            n++;
        end while (!ce6 && n < 8);
        check_bit("align_ce6", ce6, 1'b1);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] data);
        bus.wr_req  = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_data = data;
    endtask

    task automatic load_reset_model();
        for (int i = 0; i < 16; i++)
            exp_pal[i] = RESET_PAL[i*8 +: 8];
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            step();
            coloridx = 4'(i);
            dbg_idx  = 4'(15 - i);
            #1;
            check("sweep_realcolor", realcolor, exp_pal[i]);
            check("sweep_dbg", dbg_data, exp_pal[15 - i]);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        ce6         = 1'b0;
        coloridx    = 4'd5;
        dbg_idx     = 4'd0;
        bus.wr_req  = 1'b0;
        bus.wr_idx  = 4'd0;
        bus.wr_data = 8'd0;
        bus.ovr_clr = 1'b0;
        load_reset_model();

        // ---- reset: entry 5 visible, nothing pending ----
        repeat (2) step();
        check("rst_realcolor5", realcolor, 8'hA5);
        check_bit("rst_pending", bus.wr_pending, 1'b0);
        check_bit("rst_overrun", bus.wr_overrun, 1'b0);
        check("rst_dbg0", dbg_data, 8'h00);
        reset_n = 1'b1;
        step();
        check("post_rst_realcolor5", realcolor, 8'hA5);
        check_bit("post_rst_pending", bus.wr_pending, 1'b0);

        // ---- single write idx3=1C: commit after P16, visible after P17 ----
        coloridx = 4'd3;
        align();
        step(); wr(4'd3, 8'h1C);
        for (int k = 2; k <= 17; k++) begin
            step();
            check_bit("w1_pending", bus.wr_pending, 1'b1);
            check("w1_not_early", realcolor, 8'h03);
        end
        step();
        check_bit("w1_pending_done", bus.wr_pending, 1'b0);
        check("w1_visible", realcolor, 8'h1C);
        check_bit("w1_no_overrun", bus.wr_overrun, 1'b0);
        exp_pal[3] = 8'h1C;

        // ---- back-to-back: 11 replaced by 22 after two ticks ----
        coloridx = 4'd2;
        align();
        step(); wr(4'd2, 8'h11);
        for (int k = 2; k <= 9; k++) begin
            step();
            check_bit("b2b_ovr_before", bus.wr_overrun, 1'b0);
            check("b2b_hold_a", realcolor, 8'h02);
            if (k == 9) wr(4'd2, 8'h22);
        end
        for (int k = 10; k <= 25; k++) begin
            step();
            check_bit("b2b_overrun", bus.wr_overrun, 1'b1);
            check_bit("b2b_pending", bus.wr_pending, 1'b1);
            check("b2b_never_11", realcolor, 8'h02);
        end
        step();
        check("b2b_visible22", realcolor, 8'h22);
        check_bit("b2b_pending_done", bus.wr_pending, 1'b0);
        check_bit("b2b_ovr_sticky", bus.wr_overrun, 1'b1);
        bus.ovr_clr = 1'b1;
        step();
        check_bit("b2b_ovr_cleared", bus.wr_overrun, 1'b0);
        exp_pal[2] = 8'h22;

        // ---- request on the COMMIT cycle: 7 commits, 8 then pends ----
        coloridx = 4'd8;
        dbg_idx  = 4'd7;
        align();
        step(); wr(4'd7, 8'h5A);
        for (int k = 2; k <= 16; k++) step();
        step();
        check_bit("cc_in_commit_pending", bus.wr_pending, 1'b1);
        check("cc_entry7_old", dbg_data, 8'h07);
        wr(4'd8, 8'hF0);
        step();
        check("cc_entry7_written", dbg_data, 8'h5A);
        check_bit("cc_pending_stays", bus.wr_pending, 1'b1);
        check_bit("cc_overrun", bus.wr_overrun, 1'b1);
        for (int k = 19; k <= 33; k++) begin
            step();
            check("cc_entry8_old", realcolor, 8'h08);
            check_bit("cc_pending2", bus.wr_pending, 1'b1);
        end
        step();
        check("cc_entry8_F0", realcolor, 8'hF0);
        check_bit("cc_pending_done", bus.wr_pending, 1'b0);
        exp_pal[7] = 8'h5A;
        exp_pal[8] = 8'hF0;
        bus.ovr_clr = 1'b1;
        step();
        check_bit("cc_ovr_cleared", bus.wr_overrun, 1'b0);

        // ---- readback sweep of the modified palette ----
        sweep();

        // ---- reset in the middle of WAIT discards the write to 9 ----
        coloridx = 4'd9;
        dbg_idx  = 4'd3;
        align();
        step(); wr(4'd9, 8'h77);
        for (int k = 2; k <= 6; k++) step();
        check_bit("mid_pending_before", bus.wr_pending, 1'b1);
        reset_n = 1'b0;
        #1;
        load_reset_model();
        check_bit("mid_rst_pending", bus.wr_pending, 1'b0);
        check("mid_rst_entry9", realcolor, 8'h99);
        check("mid_rst_entry3", dbg_data, 8'h03);
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            step();
            check("mid_entry9_kept", realcolor, 8'h99);
            check_bit("mid_idle", bus.wr_pending, 1'b0);
        end

        // ---- readback sweep after reset ----
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
